// File: rtl/ryuki_datatypes.sv
// Shared trace datatypes for the ryuki pipeline trackers.
// Trace element layout, EX tracker state encoding, and small helpers.
package ryuki_datatypes;

  localparam int TRACE_ADDR_W = 32;
  localparam int TRACE_DATA_W = 32;

  typedef struct packed {
    integer time_start;
    integer time_end;
  } stage_time_t;

  typedef struct packed {
    logic [TRACE_ADDR_W-1:0] pc;
    logic [31:0]             instr;
    logic [TRACE_ADDR_W-1:0] mem_addr;
    logic [TRACE_DATA_W-1:0] mem_data;
    stage_time_t             if_data;
    stage_time_t             id_data;
    stage_time_t             ex_data;
  } trace_output;

  typedef enum logic [1:0] {
    IDLE,
    EXEC_START,
    EXEC_END,
    OUTPUT
  } ex_tracker_state_t;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ex_tracker_fifo.sv
// Small synchronous FIFO of trace elements between ID and EX trackers.
// Head is read combinationally; a pop frees a slot for a same-cycle push.
module trace_fifo
  import ryuki_datatypes::*;
#(
  parameter int  FIFO_DEPTH = 4,
  parameter type T          = trace_output
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  T           mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ex_tracker.sv
// EX-stage trace tracker: buffers ID elements, stamps EX start/end times.
// Optional EX_TRACKER_DROP_COUNT_EN adds a saturating drop_count output.
module ex_tracker
  import ryuki_datatypes::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] counter,
  input  logic        id_data_valid,
  input  trace_output id_data_in,
  input  logic        is_executing,
  output logic        ex_data_valid,
  output trace_output ex_data_out,
  input  logic        ex_data_ready,
  output logic        fifo_full,
  output logic        drop_pulse
`ifdef EX_TRACKER_DROP_COUNT_EN
  ,
  output logic [31:0] drop_count
`endif
);

  if (ADDR_WIDTH != TRACE_ADDR_W ||
      DATA_WIDTH != TRACE_DATA_W) begin : g_width_chk
    $error("ex_tracker: widths must match trace_output");
  end

  if (!is_pow2(FIFO_DEPTH)) begin : g_depth_chk
    $error("ex_tracker: FIFO_DEPTH must be a power of two >= 2");
  end

  ex_tracker_state_t state;
  trace_output       trace_element;
  trace_output       fifo_head;
  logic              fifo_empty;
  logic              handshake;
  logic              pop;
  logic              drop;

  assign handshake = ex_data_valid && ex_data_ready;

  // Head leaves the FIFO when idle, or right on the output handshake.
  assign pop = !fifo_empty &&
               ((state == IDLE) ||
                (state == OUTPUT && handshake));

  // A pop on the same edge makes room, so only a stuck-full FIFO drops.
  assign drop = id_data_valid && fifo_full && !pop;

  trace_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .T          (trace_output)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (id_data_valid),
    .din   (id_data_in),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Element lifecycle: load, stamp start, stamp end, hand off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      trace_element <= '0;
      ex_data_out   <= '0;
      ex_data_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            trace_element <= fifo_head;
            state         <= EXEC_START;
          end
        end
        EXEC_START: begin
          if (is_executing) begin
            trace_element.ex_data.time_start <= counter;
            state <= EXEC_END;
          end
        end
        EXEC_END: begin
          if (!is_executing) begin
            trace_element.ex_data.time_end <= counter;
            ex_data_out                    <= trace_element;
            ex_data_out.ex_data.time_end   <= counter;
            ex_data_valid                  <= 1'b1;
            state                          <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (ex_data_ready) begin
            ex_data_valid <= 1'b0;
            if (pop) begin
              trace_element <= fifo_head;
              state         <= EXEC_START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-cycle pulse for each discarded element.
  always_ff @(posedge clk) begin
    if (rst) drop_pulse <= 1'b0;
    else     drop_pulse <= drop;
  end

`ifdef EX_TRACKER_DROP_COUNT_EN
  // Saturating count of discarded elements.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop && drop_count != 32'hFFFF_FFFF) begin
      drop_count <= drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_tracker.sv
// Self-checking bench for ex_tracker.
// Queue-based model plus directed scenarios with literal expectations.
module tb_ex_tracker;
  import ryuki_datatypes::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] counter;
  logic        id_data_valid;
  trace_output id_data_in;
  logic        is_executing;
  logic        ex_data_valid;
  trace_output ex_data_out;
  logic        ex_data_ready;
  logic        fifo_full;
  logic        drop_pulse;
`ifdef EX_TRACKER_DROP_COUNT_EN
  logic [31:0] drop_count;
`endif

  int checks = 0;
  int errors = 0;

  ex_tracker #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .counter       (counter),
    .id_data_valid (id_data_valid),
    .id_data_in    (id_data_in),
    .is_executing  (is_executing),
    .ex_data_valid (ex_data_valid),
    .ex_data_out   (ex_data_out),
    .ex_data_ready (ex_data_ready),
    .fifo_full     (fifo_full),
    .drop_pulse    (drop_pulse)
`ifdef EX_TRACKER_DROP_COUNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk1(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chkt(input string nm, input trace_output act,
                      input trace_output exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic trace_output mk(input logic [31:0] pc);
    trace_output t;
    t.pc                 = pc;
    t.instr              = ~pc;
    t.mem_addr           = pc + 32'h1000;
    t.mem_data           = {pc[15:0], pc[15:0]};
    t.if_data.time_start = 100;
    t.if_data.time_end   = 101;
    t.id_data.time_start = 102;
    t.id_data.time_end   = 103;
    t.ex_data.time_start = -5;
    t.ex_data.time_end   = -6;
    return t;
  endfunction

  // Model: pending queue plus one job in one of four phases.
  localparam int J_NONE  = 0;
  localparam int J_START = 1;
  localparam int J_END   = 2;
  localparam int J_OUT   = 3;

  trace_output mq[$];
  trace_output cur;
  trace_output m_out;
  int          phase   = J_NONE;
  bit          m_valid = 1'b0;
  bit          m_drop  = 1'b0;
  logic [31:0] m_drops = '0;
  bit          armed   = 1'b0;

  trace_output got[$];
  int          drop_seen = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        phase   = J_NONE;
        m_valid = 1'b0;
        m_out   = '0;
        m_drop  = 1'b0;
        m_drops = '0;
        armed   = 1'b1;
      end else begin
        if (phase == J_NONE || (phase == J_OUT && ex_data_ready)) begin
          m_valid = 1'b0;
          if (mq.size() > 0) begin
            cur   = mq.pop_front();
            phase = J_START;
          end else begin
            phase = J_NONE;
          end
        end else if (phase == J_START && is_executing) begin
          cur.ex_data.time_start = counter;
          phase = J_END;
        end else if (phase == J_END && !is_executing) begin
          cur.ex_data.time_end = counter;
          m_out   = cur;
          m_valid = 1'b1;
          phase   = J_OUT;
        end
        m_drop = 1'b0;
        if (id_data_valid) begin
          if (mq.size() < DEPTH) begin
            mq.push_back(id_data_in);
          end else begin
            m_drop = 1'b1;
            if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk1("valid", 32'(ex_data_valid), 32'(m_valid));
        chk1("full", 32'(fifo_full), 32'(mq.size() == DEPTH));
        chk1("drop_pulse", 32'(drop_pulse), 32'(m_drop));
        if (m_valid) chkt("data_out", ex_data_out, m_out);
`ifdef EX_TRACKER_DROP_COUNT_EN
        chk1("drop_count", drop_count, m_drops);
`endif
        if (ex_data_valid && ex_data_ready) got.push_back(ex_data_out);
        if (drop_pulse) drop_seen++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    counter       = counter + 1;
    id_data_valid = 1'b0;
  endtask

  task automatic push_el(input logic [31:0] pc);
    id_data_valid = 1'b1;
    id_data_in    = mk(pc);
  endtask

  task automatic chk_got(input int idx, input logic [31:0] pc);
    checks++;
    if (idx >= got.size()) begin
      errors++;
      $display("FAIL got_%0d: only %0d outputs, expected pc %h",
               idx, got.size(), pc);
    end else if (got[idx].pc !== pc) begin
      errors++;
      $display("FAIL got_%0d: pc %h, expected %h", idx, got[idx].pc, pc);
    end
  endtask

  int          d0;
  int          n0;
  logic [31:0] c_a;

  initial begin
    rst           = 1'b1;
    counter       = '0;
    id_data_valid = 1'b0;
    id_data_in    = '0;
    is_executing  = 1'b0;
    ex_data_ready = 1'b0;
    cyc();
    cyc();
    chk1("rst_valid", 32'(ex_data_valid), 32'd0);
    chk1("rst_full", 32'(fifo_full), 32'd0);
    chk1("rst_drop", 32'(drop_pulse), 32'd0);
    chkt("rst_out", ex_data_out, '0);
    rst = 1'b0;
    cyc();

    // Single element: push at 10, executing 13..15, low at 16.
    counter = 32'd10;
    push_el(32'h100);
    cyc();
    cyc();
    cyc();
    is_executing = 1'b1;
    cyc();
    cyc();
    cyc();
    is_executing = 1'b0;
    cyc();
    chk1("single_valid", 32'(ex_data_valid), 32'd1);
    chk1("single_start", ex_data_out.ex_data.time_start, 32'd13);
    chk1("single_end", ex_data_out.ex_data.time_end, 32'd16);
    chk1("single_pc", ex_data_out.pc, 32'h100);
    cyc();
    cyc();
    ex_data_ready = 1'b1;
    cyc();
    chk_got(0, 32'h100);

    // Back-to-back: B must start right after A's handshake.
    is_executing = 1'b1;
    push_el(32'h200);
    cyc();
    push_el(32'h204);
    cyc();
    cyc();
    is_executing = 1'b0;
    c_a = counter;
    cyc();
    is_executing = 1'b1;
    cyc();
    cyc();
    is_executing = 1'b0;
    cyc();
    cyc();
    chk_got(1, 32'h200);
    chk_got(2, 32'h204);
    if (got.size() > 2) begin
      chk1("b2b_a_end", got[1].ex_data.time_end, c_a);
      chk1("b2b_b_start", got[2].ex_data.time_start, c_a + 32'd2);
    end else begin
      chk1("b2b_outputs", 32'(got.size()), 32'd3);
    end

    // Overflow: stall X in output, then push six elements.
    ex_data_ready = 1'b0;
    is_executing  = 1'b1;
    push_el(32'h300);
    cyc();
    cyc();
    cyc();
    is_executing = 1'b0;
    cyc();
    d0 = drop_seen;
    for (int i = 0; i < 6; i++) begin
      push_el(32'h310 + 32'(i * 4));
      cyc();
    end
    cyc();
    chk1("ovf_full", 32'(fifo_full), 32'd1);
    chk1("ovf_drops", 32'(drop_seen - d0), 32'd2);
`ifdef EX_TRACKER_DROP_COUNT_EN
    chk1("ovf_drop_count", drop_count, 32'd2);
`endif

    // Full FIFO with a pop on the same edge as a push.
    ex_data_ready = 1'b1;
    push_el(32'h340);
    cyc();
    chk1("fullpop_full", 32'(fifo_full), 32'd1);
    ex_data_ready = 1'b0;
    cyc();
    chk1("fullpop_nodrop", 32'(drop_seen - d0), 32'd2);

    ex_data_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      is_executing = ~is_executing;
      cyc();
    end
    chk1("drain_count", 32'(got.size()), 32'd9);
    chk_got(3, 32'h300);
    chk_got(4, 32'h310);
    chk_got(5, 32'h314);
    chk_got(6, 32'h318);
    chk_got(7, 32'h31C);
    chk_got(8, 32'h340);

    // Reset while in EXEC_END with three buffered elements.
    is_executing = 1'b0;
    push_el(32'h400);
    cyc();
    push_el(32'h404);
    cyc();
    is_executing = 1'b1;
    push_el(32'h408);
    cyc();
    push_el(32'h40C);
    cyc();
    chk1("mid_full_pre", 32'(fifo_full), 32'd0);
    rst = 1'b1;
    cyc();
    chk1("mid_valid", 32'(ex_data_valid), 32'd0);
    chk1("mid_full", 32'(fifo_full), 32'd0);
    rst = 1'b0;
    n0 = got.size();
    for (int i = 0; i < 15; i++) begin
      is_executing = ~is_executing;
      cyc();
    end
    chk1("mid_no_output", 32'(got.size()), 32'(n0));

    // Counter wrap: start at 7FFF_FFFF, end after the wrap.
    is_executing = 1'b0;
    counter      = 32'h7FFF_FFFC;
    push_el(32'h500);
    cyc();
    cyc();
    cyc();
    is_executing = 1'b1;
    cyc();
    is_executing = 1'b0;
    cyc();
    cyc();
    cyc();
    chk_got(n0, 32'h500);
    if (got.size() > n0) begin
      chk1("wrap_start", got[n0].ex_data.time_start, 32'h7FFF_FFFF);
      chk1("wrap_end", got[n0].ex_data.time_end, 32'h8000_0000);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
